// File: rtl/exprom_pkg.sv
// Shared types and constants for the expansion-ROM arbiter.
// Holds state/grant enums and ROM geometry constants.
package exprom_pkg;

  localparam int EXPROM_ADDR_W = 9;
  localparam int EXPROM_DATA_W = 32;
  localparam logic [31:0] EXPROM_BAR_DISABLED_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_PCI = 1'b0,
    GNT_MGT = 1'b1
  } gnt_e;

endpackage

// File: rtl/exprom_arbiter_if.sv
// Requester and ROM-pin bundle for exprom_arbiter.
// master: requesters + ROM model side; slave: the arbiter.
interface exprom_arbiter_if
  import exprom_pkg::*;
#(
  parameter int ADDR_W = EXPROM_ADDR_W,
  parameter int DATA_W = EXPROM_DATA_W
);
  logic              pci_req;
  logic [ADDR_W-1:0] pci_addr;
  logic              pci_ack;
  logic              pci_rvalid;
  logic [DATA_W-1:0] pci_rdata;

  logic              mgt_req;
  logic              mgt_we;
  logic [ADDR_W-1:0] mgt_addr;
  logic [DATA_W-1:0] mgt_wdata;
  logic              mgt_ack;
  logic              mgt_rvalid;
  logic [DATA_W-1:0] mgt_rdata;
  logic              mgt_err;

  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_dinp;
  logic              rom_wren;
  logic              rom_enable;
  logic [DATA_W-1:0] rom_dout;

  modport master (
    output pci_req, pci_addr,
    input  pci_ack, pci_rvalid, pci_rdata,
    output mgt_req, mgt_we, mgt_addr, mgt_wdata,
    input  mgt_ack, mgt_rvalid, mgt_rdata, mgt_err,
    input  rom_address, rom_dinp, rom_wren, rom_enable,
    output rom_dout
  );

  modport slave (
    input  pci_req, pci_addr,
    output pci_ack, pci_rvalid, pci_rdata,
    input  mgt_req, mgt_we, mgt_addr, mgt_wdata,
    output mgt_ack, mgt_rvalid, mgt_rdata, mgt_err,
    output rom_address, rom_dinp, rom_wren, rom_enable,
    input  rom_dout
  );

endinterface

// File: rtl/exprom_prio_arb.sv
// PCI-priority winner select with management starvation guard.
// In: clk, rst, arb_en_i, pci_req_i, mgt_req_i. Out: gnt_vld_o, gnt_o.
module exprom_prio_arb
  import exprom_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic pci_req_i,
  input  logic mgt_req_i,
  output logic gnt_vld_o,
  output gnt_e gnt_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       starve;

  assign starve = (cnt_q == 4'(STARVE_MAX));

  always_comb begin
    gnt_vld_o = pci_req_i | mgt_req_i;
    gnt_o     = GNT_PCI;
    if (mgt_req_i && (!pci_req_i || starve))
      gnt_o = GNT_MGT;
  end

  // Counts PCI wins only while management is waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (!mgt_req_i)
      cnt_d = '0;
    else if (arb_en_i && gnt_vld_o)
      cnt_d = (gnt_o == GNT_MGT) ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/exprom_arbiter.sv
// Shares the expansion-ROM BRAM between PCI reads and mgmt access.
// Ports: clk, rst, rom_bar_en, bus (slave); wr_unlock if EXPROM_WRLOCK_EN.
module exprom_arbiter
  import exprom_pkg::*;
#(
  parameter int ADDR_W     = EXPROM_ADDR_W,
  parameter int DATA_W     = EXPROM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rom_bar_en,
`ifdef EXPROM_WRLOCK_EN
  input  logic wr_unlock,
`endif
  exprom_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_RESP  = ST_RESP;

  logic [1:0]        state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              bar_off_q, bar_off_d;
  logic              lock_q, lock_d;
  logic [DATA_W-1:0] prd_q, prd_d;
  logic [DATA_W-1:0] mrd_q, mrd_d;

  logic arb_en;
  logic gnt_vld;
  gnt_e gnt;
  logic unlock;
  logic issue;
  logic resp;

`ifdef EXPROM_WRLOCK_EN
  assign unlock = wr_unlock;
`else
  assign unlock = 1'b1;
`endif

  assign arb_en = (state_q == S_IDLE) || (state_q == S_RESP);
  assign issue  = (state_q == S_ISSUE);
  assign resp   = (state_q == S_RESP);

  exprom_prio_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .arb_en_i (arb_en),
    .pci_req_i(bus.pci_req),
    .mgt_req_i(bus.mgt_req),
    .gnt_vld_o(gnt_vld),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    bar_off_d = bar_off_q;
    lock_d    = lock_q;
    prd_d     = prd_q;
    mrd_d     = mrd_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (gnt_vld) begin
          state_d = S_ISSUE;
          gnt_d   = gnt;
          if (gnt == GNT_PCI) begin
            addr_d    = bus.pci_addr;
            wdata_d   = '0;
            we_d      = 1'b0;
            bar_off_d = !rom_bar_en;
            lock_d    = 1'b0;
          end else begin
            addr_d    = bus.mgt_addr;
            wdata_d   = bus.mgt_wdata;
            we_d      = bus.mgt_we;
            bar_off_d = 1'b0;
            lock_d    = bus.mgt_we && !unlock;
          end
        end
      end
      S_ISSUE: state_d = S_DATA;
      S_DATA: begin
        state_d = S_RESP;
        // BRAM output is valid this cycle; latch into the winner.
        if (gnt_q == GNT_PCI)
          prd_d = bar_off_q ? DATA_W'(EXPROM_BAR_DISABLED_DATA)
                            : bus.rom_dout;
        else if (!we_q)
          mrd_d = bus.rom_dout;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= GNT_PCI;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      bar_off_q <= 1'b0;
      lock_q    <= 1'b0;
      prd_q     <= '0;
      mrd_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      bar_off_q <= bar_off_d;
      lock_q    <= lock_d;
      prd_q     <= prd_d;
      mrd_q     <= mrd_d;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign bus.pci_ack    = issue && (gnt_q == GNT_PCI);
  assign bus.pci_rvalid = resp && (gnt_q == GNT_PCI);
  assign bus.pci_rdata  = prd_q;

  assign bus.mgt_ack    = issue && (gnt_q == GNT_MGT);
  assign bus.mgt_rvalid = resp && (gnt_q == GNT_MGT) && !we_q;
  assign bus.mgt_rdata  = mrd_q;
`ifdef EXPROM_WRLOCK_EN
  assign bus.mgt_err    = resp && (gnt_q == GNT_MGT) && lock_q;
`else
  assign bus.mgt_err    = 1'b0;
`endif

  // Blocked writes and BAR-disabled reads never touch the BRAM.
  assign bus.rom_enable  = issue && !bar_off_q && !lock_q;
  assign bus.rom_wren    = issue && we_q && !lock_q;
  assign bus.rom_address = issue ? addr_q : '0;
  assign bus.rom_dinp    = (issue && we_q && !lock_q) ? wdata_q : '0;

endmodule
